// File: rtl/keyboard_key_tracker.sv
// Multi-key pressed-state tracker: per-key held state plus press, release and
// timer-driven auto-repeat pulses derived from a make/break scan-code stream.
module keyboard_key_tracker #(
  parameter int NUM_KEYS     = 4,
  parameter int CODE_W       = 8,
  parameter int REPEAT_DELAY = 5,
  parameter int REPEAT_RATE  = 3
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_KEYS*CODE_W-1:0] keyCodes,
  input  logic [CODE_W-1:0]          outCode,
  input  logic                       makeBreak,
  input  logic                       code_valid,
  input  logic                       clear,
  output logic [NUM_KEYS-1:0]        pressed,
  output logic [NUM_KEYS-1:0]        press_pulse,
  output logic [NUM_KEYS-1:0]        release_pulse,
  output logic [NUM_KEYS-1:0]        repeat_pulse,
  output logic                       any_pressed
);

  localparam int MAX_TICKS = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W     = (MAX_TICKS < 1) ? 1 : $clog2(MAX_TICKS + 1);

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE);

  typedef enum logic [1:0] {
    UNPRESSED,
    HELD_DELAY,
    HELD_REPEAT
  } key_state_e;

  logic [NUM_KEYS-1:0] is_make;
  logic [NUM_KEYS-1:0] is_break;
  logic [NUM_KEYS-1:0] held;
  logic [NUM_KEYS-1:0] pressed_next;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             match;
    logic             press_q;
    logic             release_q;
    logic             repeat_q;

    // Keys sharing a scan code all match the same event and move together.
    assign match        = code_valid && (outCode == keyCodes[i*CODE_W +: CODE_W]);
    assign is_make[i]   = match && makeBreak;
    assign is_break[i]  = match && !makeBreak;
    assign held[i]      = (state != UNPRESSED);

    // Clear beats break beats make; a make on a held key changes nothing.
    assign pressed_next[i] = clear   ? 1'b0 :
                             held[i] ? !is_break[i] :
                                       is_make[i];

    assign press_pulse[i]   = press_q;
    assign release_pulse[i] = release_q;
    assign repeat_pulse[i]  = repeat_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state     <= UNPRESSED;
        cnt       <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        repeat_q  <= 1'b0;
      end else begin
        // NOTE: non-blocking assignments so every read below sees the pre-edge
        // state; pulses default low and only the firing branch raises one.
        press_q   <= 1'b0;
        release_q <= 1'b0;
        repeat_q  <= 1'b0;

        if (clear || is_break[i]) begin
          // A release cancels any repeat that would have fired this cycle.
          if (held[i]) begin
            state     <= UNPRESSED;
            cnt       <= '0;
            release_q <= 1'b1;
          end
        end else begin
          case (state)
            UNPRESSED: begin
              if (is_make[i]) begin
                state   <= HELD_DELAY;
                cnt     <= CNT_ONE;
                press_q <= 1'b1;
              end
            end
            HELD_DELAY: begin
              // With no delay configured the key parks here with the timer frozen.
              if (REPEAT_DELAY != 0) begin
                if (cnt == DELAY_LAST) begin
                  state    <= HELD_REPEAT;
                  cnt      <= CNT_ONE;
                  repeat_q <= 1'b1;
                end else begin
                  cnt <= cnt + CNT_ONE;
                end
              end
            end
            HELD_REPEAT: begin
              if (cnt == RATE_LAST) begin
                cnt      <= CNT_ONE;
                repeat_q <= 1'b1;
              end else begin
                cnt <= cnt + CNT_ONE;
              end
            end
            default: begin
              state <= UNPRESSED;
              cnt   <= '0;
            end
          endcase
        end
      end
    end
  end

  // Held state and its OR are registered from the same next-state term so
  // any_pressed never lags pressed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pressed     <= '0;
      any_pressed <= 1'b0;
    end else begin
      pressed     <= pressed_next;
      any_pressed <= |pressed_next;
    end
  end

endmodule
